// File: rtl/tail_light_seq.sv
// tail_light_seq: sequential tail-light controller with turn fill,
// hazard flashing and brake overlay, stepped by an internal prescaler.
module tail_light_seq #(
  parameter int N_LAMPS = 3,
  parameter int DIV     = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               left_i,
  input  logic               right_i,
  input  logic               haz_i,
  input  logic               brake_i,
  output logic [N_LAMPS-1:0] l_o,
  output logic [N_LAMPS-1:0] r_o,
  output logic               step_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = $clog2(N_LAMPS + 1);
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(N_LAMPS);

  typedef enum logic [2:0] {
    IDLE,
    LSEQ,
    RSEQ,
    HAZ_ON,
    HAZ_OFF
  } state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      s_q, s_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               step_q;
  logic               tick;
  logic [N_LAMPS-1:0] l_q, l_d;
  logic [N_LAMPS-1:0] r_q, r_d;
  logic [N_LAMPS-1:0] therm;
  logic               sel_haz, sel_l, sel_r;

  assign tick    = (cnt_q == CMAX);
  assign cnt_d   = tick ? '0 : cnt_q + CW'(1);
  assign sel_haz = haz_i | (left_i & right_i);
  assign sel_l   = left_i & ~sel_haz;
  assign sel_r   = right_i & ~sel_haz;

  // Prescaler count and registered step pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= tick;
    end
  end

  // Sequencer state and step index register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
    end
  end

  // Next state: only advances on tick, hazard wins over turns.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    if (tick) begin
      if (sel_haz) begin
        state_d = (state_q == HAZ_ON) ? HAZ_OFF : HAZ_ON;
        s_d     = '0;
      end else if (sel_l) begin
        if (state_q == LSEQ) begin
          s_d = (s_q == SMAX) ? '0 : s_q + SW'(1);
        end else begin
          state_d = LSEQ;
          s_d     = SW'(1);
        end
      end else if (sel_r) begin
        if (state_q == RSEQ) begin
          s_d = (s_q == SMAX) ? '0 : s_q + SW'(1);
        end else begin
          state_d = RSEQ;
          s_d     = SW'(1);
        end
      end else begin
        state_d = IDLE;
        s_d     = '0;
      end
    end
  end

  // Lamp pattern from current state, brake forces non-turning lamps on.
  always_comb begin
    therm = '0;
    for (int i = 0; i < N_LAMPS; i++) begin
      therm[i] = (i < int'(s_q));
    end
    l_d = '0;
    r_d = '0;
    unique case (state_q)
      LSEQ:    l_d = therm;
      RSEQ:    r_d = therm;
      HAZ_ON: begin
        l_d = '1;
        r_d = '1;
      end
      default: ;
    endcase
    if (brake_i) begin
      l_d = (state_q == LSEQ) ? therm : '1;
      r_d = (state_q == RSEQ) ? therm : '1;
    end
  end

  // Registered lamp outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      l_q <= '0;
      r_q <= '0;
    end else begin
      l_q <= l_d;
      r_q <= r_d;
    end
  end

  assign l_o    = l_q;
  assign r_o    = r_q;
  assign step_o = step_q;

endmodule

// File: tb/tb_tail_light_seq.sv
// tb_tail_light_seq: scoreboard bench for tail_light_seq, default
// instance plus a 5-lamp, DIV=1 instance.
module tb_tail_light_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, left_a, right_a, haz_a, brake_a;
  logic [2:0] l_a, r_a;
  logic       step_a;
  logic       rst_b, left_b, right_b, haz_b, brake_b;
  logic [4:0] l_b, r_b;
  logic       step_b;

  tail_light_seq #(.N_LAMPS(3), .DIV(4)) u_a (
    .clk_i   (clk),
    .rst_i   (rst_a),
    .left_i  (left_a),
    .right_i (right_a),
    .haz_i   (haz_a),
    .brake_i (brake_a),
    .l_o     (l_a),
    .r_o     (r_a),
    .step_o  (step_a)
  );

  tail_light_seq #(.N_LAMPS(5), .DIV(1)) u_b (
    .clk_i   (clk),
    .rst_i   (rst_b),
    .left_i  (left_b),
    .right_i (right_b),
    .haz_i   (haz_b),
    .brake_i (brake_b),
    .l_o     (l_b),
    .r_o     (r_b),
    .step_o  (step_b)
  );

  typedef struct {
    logic [4:0] l;
    logic [4:0] r;
    logic       st;
    string      nm;
  } exp_t;

  exp_t  qa[$];
  exp_t  qb[$];
  exp_t  ea, eb;
  int    n_chk = 0;
  int    n_err = 0;
  int    ecnt_a = 0;
  int    ecnt_b = 0;
  string ph_a = "init";
  string ph_b = "init";

  function automatic void chk(string nm, logic [4:0] act,
                              logic [4:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endfunction

  // Expected values for the state after the next clock edge.
  task automatic rep_a(int n, logic [4:0] l, logic [4:0] r);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ecnt_a++;
      qa.push_back('{l: l, r: r, st: (ecnt_a % 4 == 0), nm: ph_a});
    end
  endtask

  task automatic rep_b(int n, logic [4:0] l, logic [4:0] r);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ecnt_b++;
      qb.push_back('{l: l, r: r, st: 1'b1, nm: ph_b});
    end
  endtask

  // Monitor: compare outputs against the scoreboard every cycle.
  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk({"A_", ea.nm, "_L"}, {2'b00, l_a}, ea.l);
      chk({"A_", ea.nm, "_R"}, {2'b00, r_a}, ea.r);
      chk({"A_", ea.nm, "_step"}, {4'b0, step_a}, {4'b0, ea.st});
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk({"B_", eb.nm, "_L"}, l_b, eb.l);
      chk({"B_", eb.nm, "_R"}, r_b, eb.r);
      chk({"B_", eb.nm, "_step"}, {4'b0, step_b}, {4'b0, eb.st});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    {rst_a, left_a, right_a, haz_a, brake_a} = '0;
    {rst_b, left_b, right_b, haz_b, brake_b} = '0;
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("A_reset_L", {2'b00, l_a}, 5'd0);
    chk("A_reset_R", {2'b00, r_a}, 5'd0);
    chk("A_reset_step", {4'b0, step_a}, 5'd0);

    ph_a = "left";
    left_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    ecnt_a = 0;
    rep_a(4, 0, 0);
    rep_a(4, 1, 0);
    rep_a(4, 3, 0);
    rep_a(4, 7, 0);
    rep_a(4, 0, 0);
    rep_a(4, 1, 0);
    rep_a(1, 3, 0);

    ph_a = "dirchg";
    left_a = 1'b0;
    right_a = 1'b1;
    rep_a(3, 3, 0);
    rep_a(4, 0, 1);
    rep_a(4, 0, 3);
    rep_a(4, 0, 7);
    rep_a(4, 0, 0);
    rep_a(4, 0, 1);
    rep_a(1, 0, 3);

    ph_a = "brake_turn";
    brake_a = 1'b1;
    rep_a(3, 7, 3);
    rep_a(4, 7, 7);
    rep_a(1, 7, 0);
    ph_a = "brake_off";
    brake_a = 1'b0;
    rep_a(3, 0, 0);
    rep_a(1, 0, 1);

    ph_a = "haz_lr";
    left_a = 1'b1;
    rep_a(3, 0, 1);
    rep_a(4, 7, 7);
    rep_a(1, 0, 0);
    ph_a = "haz_all";
    haz_a = 1'b1;
    rep_a(3, 0, 0);
    rep_a(4, 7, 7);
    rep_a(4, 0, 0);
    rep_a(1, 7, 7);
    ph_a = "brake_haz";
    brake_a = 1'b1;
    rep_a(3, 7, 7);
    rep_a(2, 7, 7);
    ph_a = "haz_resume";
    brake_a = 1'b0;
    rep_a(2, 0, 0);
    rep_a(2, 7, 7);

    @(negedge clk);
    #1;
    rst_a = 1'b1;
    #1;
    chk("A_midrst_L", {2'b00, l_a}, 5'd0);
    chk("A_midrst_R", {2'b00, r_a}, 5'd0);
    chk("A_midrst_step", {4'b0, step_a}, 5'd0);
    {left_a, right_a, haz_a} = '0;
    repeat (2) @(posedge clk);
    ph_a = "post_rst";
    @(negedge clk);
    rst_a = 1'b0;
    ecnt_a = 0;
    rep_a(5, 0, 0);
    ph_a = "pulse";
    right_a = 1'b1;
    rep_a(1, 0, 0);
    right_a = 1'b0;
    rep_a(6, 0, 0);

    ph_b = "right5";
    right_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    ecnt_b = 0;
    rep_b(1, 0, 5'b00000);
    rep_b(1, 0, 5'b00001);
    rep_b(1, 0, 5'b00011);
    rep_b(1, 0, 5'b00111);
    rep_b(1, 0, 5'b01111);
    rep_b(1, 0, 5'b11111);
    rep_b(1, 0, 5'b00000);
    rep_b(1, 0, 5'b00001);
    ph_b = "release5";
    right_b = 1'b0;
    rep_b(1, 0, 5'b00011);
    rep_b(2, 0, 5'b00000);

    @(negedge clk);
    #1;
    n_chk++;
    if (qa.size() + qb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0",
               qa.size() + qb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
